// File: rtl/sm_fv_bank_cntl_pkg.sv
//------------------------------------------------------------------------------
// sm_fv_bank_cntl_pkg : shared types and constants for the small FV bank.
// Optional build macro: SM_FV_PARITY_EN (adds an even-parity bit per line).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sm_fv_bank_cntl_pkg;

  localparam int FV_BW          = 32;
  localparam int DEPTH          = 64;
  localparam int LINES_PER_NODE = 8;
  localparam int NUM_PE         = 4;
  localparam int ADDR_W         = $clog2(DEPTH);
  localparam int NODE_W         = $clog2(DEPTH / LINES_PER_NODE);
  localparam int LPN_LOG        = $clog2(LINES_PER_NODE);
  localparam int LEN_W          = LPN_LOG + 1;
  localparam int TAG_W          = $clog2(NUM_PE);

`ifdef SM_FV_PARITY_EN
  localparam int STORE_W = FV_BW + 1;
`else
  localparam int STORE_W = FV_BW;
`endif

  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(LINES_PER_NODE);

  // Stream beat as produced by the big FV bank controller
  typedef struct packed {
    logic              sos;
    logic              eos;
    logic [FV_BW-1:0]  data;
    logic [ADDR_W-1:0] addr;
  } fv_pkt_t;

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic [LEN_W-1:0]  len;
    logic [TAG_W-1:0]  pe_tag;
  } rd_req_t;

  typedef struct packed {
    logic             sos;
    logic             eos;
    logic [FV_BW-1:0] data;
    logic [TAG_W-1:0] pe_tag;
  } pe_out_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2,
    ST_READING = 2'd3
  } state_t;

  // Zero-length requests still return one line; oversize ones stop at a node
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0)
      return C_LEN_ONE;
    else if (len > C_LEN_MAX)
      return C_LEN_MAX;
    else
      return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm_fv_bank_cntl_if.sv
//------------------------------------------------------------------------------
// sm_fv_bank_cntl_if : stream-in, read-request and Edge PE output bundle.
// Optional build macro: SM_FV_PARITY_EN (adds rd_out_perr).  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sm_fv_bank_cntl_if;
  import sm_fv_bank_cntl_pkg::*;

  logic              fv_in_valid;
  logic              fv_in_sos;
  logic              fv_in_eos;
  logic [ADDR_W-1:0] fv_in_addr;
  logic [FV_BW-1:0]  fv_in_data;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [NODE_W-1:0] rd_req_node;
  logic [LEN_W-1:0]  rd_req_len;
  logic [TAG_W-1:0]  rd_req_pe_tag;

  logic              rd_out_valid;
  logic              rd_out_sos;
  logic              rd_out_eos;
  logic [FV_BW-1:0]  rd_out_data;
  logic [TAG_W-1:0]  rd_out_pe_tag;
`ifdef SM_FV_PARITY_EN
  logic              rd_out_perr;
`endif

  logic              bank_loaded;
  logic              load_err;

  modport slave (
    input  fv_in_valid, fv_in_sos, fv_in_eos, fv_in_addr, fv_in_data,
    input  rd_req_valid, rd_req_node, rd_req_len, rd_req_pe_tag,
    output rd_req_ready,
    output rd_out_valid, rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag,
`ifdef SM_FV_PARITY_EN
    output rd_out_perr,
`endif
    output bank_loaded, load_err
  );

  modport master (
    output fv_in_valid, fv_in_sos, fv_in_eos, fv_in_addr, fv_in_data,
    output rd_req_valid, rd_req_node, rd_req_len, rd_req_pe_tag,
    input  rd_req_ready,
    input  rd_out_valid, rd_out_sos, rd_out_eos, rd_out_data, rd_out_pe_tag,
`ifdef SM_FV_PARITY_EN
    input  rd_out_perr,
`endif
    input  bank_loaded, load_err
  );

endinterface

`default_nettype wire

// File: rtl/sm_fv_linestore.sv
//------------------------------------------------------------------------------
// sm_fv_linestore : 1W1R register array with a registered (1-cycle) read port.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sm_fv_linestore #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Array contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (we)
      r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else
      rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/sm_fv_bank_cntl.sv
//------------------------------------------------------------------------------
// sm_fv_bank_cntl : captures one FV stream, then serves tagged Edge PE bursts.
// Optional build macro: SM_FV_PARITY_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sm_fv_bank_cntl
  import sm_fv_bank_cntl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  sm_fv_bank_cntl_if.slave bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_out_valid;
  logic              r_out_sos;
  logic              r_out_eos;
  logic              r_loaded;
  logic              r_err;

  fv_pkt_t           w_pkt;
  rd_req_t           w_req;
  pe_out_t           w_out;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_req_base;
  logic [ADDR_W-1:0] w_raddr;
  logic [LEN_W-1:0]  w_req_len;
  logic [STORE_W-1:0] w_wdata;
  logic [STORE_W-1:0] w_rdata;

  assign w_pkt = '{sos: bus.fv_in_sos, eos: bus.fv_in_eos,
                   data: bus.fv_in_data, addr: bus.fv_in_addr};
  assign w_req = '{node: bus.rd_req_node, len: bus.rd_req_len,
                   pe_tag: bus.rd_req_pe_tag};

  // A stream beat always wins over a read request in READY
  assign w_req_ready = (r_state == ST_READY) && !bus.fv_in_valid;
  assign w_accept    = w_req_ready && bus.rd_req_valid;
  assign w_req_len   = eff_len(w_req.len);
  assign w_req_base  = {w_req.node, {LPN_LOG{1'b0}}};

  // Beats without sos are only stored once a load has started
  assign w_we = bus.fv_in_valid &&
                (w_pkt.sos || (r_state == ST_LOADING) || (r_state == ST_READING));

`ifdef SM_FV_PARITY_EN
  assign w_wdata = {^w_pkt.data, w_pkt.data};
`else
  assign w_wdata = w_pkt.data;
`endif

  // During a burst, fetch the line for the next beat; otherwise prefetch base
  assign w_raddr = (r_state == ST_READING) ? (r_base + ADDR_W'(r_idx)) : w_req_base;

  sm_fv_linestore #(
    .DEPTH  (DEPTH),
    .WIDTH  (STORE_W),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (w_we),
    .waddr (w_pkt.addr),
    .wdata (w_wdata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_tag       <= '0;
      r_out_valid <= 1'b0;
      r_out_sos   <= 1'b0;
      r_out_eos   <= 1'b0;
      r_loaded    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY, ST_READY: begin
          if (bus.fv_in_valid) begin
            if (w_pkt.sos) begin
              r_state  <= w_pkt.eos ? ST_READY : ST_LOADING;
              r_loaded <= w_pkt.eos;
            end else begin
              r_state  <= ST_EMPTY;
              r_loaded <= 1'b0;
              r_err    <= 1'b1;
            end
          end else if (w_accept) begin
            r_base      <= w_req_base;
            r_len       <= w_req_len;
            r_tag       <= w_req.pe_tag;
            r_idx       <= C_LEN_ONE;
            r_out_valid <= 1'b1;
            r_out_sos   <= 1'b1;
            r_out_eos   <= (w_req_len == C_LEN_ONE);
            r_state     <= ST_READING;
          end
        end
        ST_LOADING: begin
          if (bus.fv_in_valid && w_pkt.eos) begin
            r_state  <= ST_READY;
            r_loaded <= 1'b1;
          end
        end
        ST_READING: begin
          if (bus.fv_in_valid)
            r_err <= 1'b1;
          if (r_out_eos) begin
            r_out_valid <= 1'b0;
            r_out_sos   <= 1'b0;
            r_out_eos   <= 1'b0;
            r_tag       <= '0;
            r_state     <= ST_READY;
          end else begin
            r_out_sos <= 1'b0;
            r_out_eos <= ((r_idx + C_LEN_ONE) == r_len);
            r_idx     <= r_idx + C_LEN_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign w_out = '{sos:    r_out_sos,
                   eos:    r_out_eos,
                   data:   r_out_valid ? w_rdata[FV_BW-1:0] : '0,
                   pe_tag: r_tag};

  assign bus.rd_req_ready  = w_req_ready;
  assign bus.rd_out_valid  = r_out_valid;
  assign bus.rd_out_sos    = w_out.sos;
  assign bus.rd_out_eos    = w_out.eos;
  assign bus.rd_out_data   = w_out.data;
  assign bus.rd_out_pe_tag = w_out.pe_tag;
  assign bus.bank_loaded   = r_loaded;
  assign bus.load_err      = r_err;
`ifdef SM_FV_PARITY_EN
  assign bus.rd_out_perr   = r_out_valid & (^w_rdata);
`endif

endmodule

`default_nettype wire

// File: tb/tb_sm_fv_bank_cntl.sv
//------------------------------------------------------------------------------
// tb_sm_fv_bank_cntl : randomized self-checking bench against a line-array model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm_fv_bank_cntl;
  import sm_fv_bank_cntl_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sm_fv_bank_cntl_if bus();

  sm_fv_bank_cntl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: plain line array plus the two status flags
  logic [FV_BW-1:0] m_store [DEPTH];
  bit m_loaded  = 1'b0;
  bit m_loading = 1'b0;
  bit m_err     = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fv_in_valid   = 1'b0;
    bus.fv_in_sos     = 1'b0;
    bus.fv_in_eos     = 1'b0;
    bus.fv_in_addr    = '0;
    bus.fv_in_data    = '0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_req_node   = '0;
    bus.rd_req_len    = '0;
    bus.rd_req_pe_tag = '0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".loaded"}, 64'(bus.bank_loaded), 64'(m_loaded));
    check_eq({tag, ".err"},    64'(bus.load_err),    64'(m_err));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, ".valid"},  64'(bus.rd_out_valid),  64'd0);
    check_eq({tag, ".sos"},    64'(bus.rd_out_sos),    64'd0);
    check_eq({tag, ".eos"},    64'(bus.rd_out_eos),    64'd0);
    check_eq({tag, ".data"},   64'(bus.rd_out_data),   64'd0);
    check_eq({tag, ".tag"},    64'(bus.rd_out_pe_tag), 64'd0);
    check_eq({tag, ".ready"},  64'(bus.rd_req_ready),  64'd0);
    check_eq({tag, ".loaded"}, 64'(bus.bank_loaded),   64'd0);
    check_eq({tag, ".err"},    64'(bus.load_err),      64'd0);
  endtask

  // One stream beat outside of a burst
  task automatic stream_beat(input bit sos, input bit eos, input int addr, input logic [FV_BW-1:0] data);
    bus.fv_in_valid = 1'b1;
    bus.fv_in_sos   = sos;
    bus.fv_in_eos   = eos;
    bus.fv_in_addr  = ADDR_W'(addr);
    bus.fv_in_data  = data;
    tick();
    bus.fv_in_valid = 1'b0;
    if (!m_loading && !sos) begin
      m_err    = 1'b1;
      m_loaded = 1'b0;
    end else begin
      m_store[addr % DEPTH] = data;
      m_loaded  = eos;
      m_loading = !eos;
    end
  endtask

  task automatic stream_all(input bit fixed_pattern);
    int mask;
    mask = fixed_pattern ? 0 : int'($urandom_range(0, DEPTH - 1));
    for (int a = 0; a < DEPTH; a++) begin
      if (!fixed_pattern && a > 0 && $urandom_range(0, 3) == 0)
        tick();
      stream_beat(a == 0, a == DEPTH - 1, a ^ mask,
                  fixed_pattern ? FV_BW'(32'h100 + a) : FV_BW'($urandom));
      if (a == DEPTH / 2) begin
        check_eq("loading.ready", 64'(bus.rd_req_ready), 64'd0);
        check_status("loading");
      end
    end
    check_status("loaded");
  endtask

  // Request a burst and check each beat; optionally inject a stream beat or abort via reset
  task automatic do_read(input int node, input int len, input int tag, input bit inject, input int abort_at);
    int eff;
    int base;
    int inj_addr;
    logic [FV_BW-1:0] inj_data;
    eff  = (len == 0) ? 1 : ((len > LINES_PER_NODE) ? LINES_PER_NODE : len);
    base = node * LINES_PER_NODE;
    bus.rd_req_valid  = 1'b1;
    bus.rd_req_node   = NODE_W'(node);
    bus.rd_req_len    = LEN_W'(len);
    bus.rd_req_pe_tag = TAG_W'(tag);
    #1;
    check_eq("req.ready", 64'(bus.rd_req_ready), 64'd1);
    tick();
    bus.rd_req_valid  = 1'b0;
    bus.rd_req_node   = NODE_W'($urandom);
    bus.rd_req_len    = LEN_W'($urandom);
    bus.rd_req_pe_tag = TAG_W'($urandom);
    inj_addr = (base + LINES_PER_NODE + 1) % DEPTH;
    inj_data = FV_BW'($urandom);
    for (int i = 0; i < eff; i++) begin
      check_eq($sformatf("n%0d.b%0d.valid", node, i), 64'(bus.rd_out_valid), 64'd1);
      check_eq($sformatf("n%0d.b%0d.sos", node, i),   64'(bus.rd_out_sos), 64'(i == 0));
      check_eq($sformatf("n%0d.b%0d.eos", node, i),   64'(bus.rd_out_eos), 64'(i == eff - 1));
      check_eq($sformatf("n%0d.b%0d.data", node, i),  64'(bus.rd_out_data),
               64'(m_store[(base + i) % DEPTH]));
      check_eq($sformatf("n%0d.b%0d.tag", node, i),   64'(bus.rd_out_pe_tag), 64'(tag));
`ifdef SM_FV_PARITY_EN
      check_eq($sformatf("n%0d.b%0d.perr", node, i),  64'(bus.rd_out_perr), 64'd0);
`endif
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check_outputs_zero("abort");
        m_loaded  = 1'b0;
        m_loading = 1'b0;
        m_err     = 1'b0;
        return;
      end
      if (inject && i == 1) begin
        bus.fv_in_valid = 1'b1;
        bus.fv_in_sos   = 1'b0;
        bus.fv_in_eos   = 1'b0;
        bus.fv_in_addr  = ADDR_W'(inj_addr);
        bus.fv_in_data  = inj_data;
      end
      tick();
      if (inject && i == 1) begin
        bus.fv_in_valid   = 1'b0;
        m_store[inj_addr] = inj_data;
        m_err             = 1'b1;
      end
    end
    check_eq("burst.end.valid", 64'(bus.rd_out_valid), 64'd0);
    check_eq("burst.end.ready", 64'(bus.rd_req_ready), 64'd1);
    check_status("burst.end");
  endtask

  task automatic random_reads(input int n);
    for (int k = 0; k < n; k++)
      do_read(int'($urandom_range(0, (DEPTH / LINES_PER_NODE) - 1)),
              int'($urandom_range(0, (1 << LEN_W) - 1)),
              int'($urandom_range(0, NUM_PE - 1)), 1'b0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    tick();
    tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    tick();
    check_outputs_zero("post_reset");

    // Directed load and read of node 2
    stream_all(1'b1);
    do_read(2, 8, 3, 1'b0, -1);
    random_reads(16);
    do_read(1, 0, 1, 1'b0, -1);
    do_read(6, 12, 2, 1'b0, -1);

    // Single-beat stream replaces line 5 only
    stream_beat(1'b1, 1'b1, 5, FV_BW'($urandom));
    check_status("single");
    do_read(0, 1, 0, 1'b0, -1);
    do_read(0, 8, 1, 1'b0, -1);

    // Stray stream beat during a burst
    do_read(3, 8, 2, 1'b1, -1);
    stream_all(1'b0);
    random_reads(10);

    // Reset in the middle of a burst
    do_read(4, 8, 1, 1'b0, 3);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("after_abort.ready", 64'(bus.rd_req_ready), 64'd0);
      check_eq("after_abort.valid", 64'(bus.rd_out_valid), 64'd0);
    end

    // Headless beat while empty
    stream_beat(1'b0, 1'b0, 7, FV_BW'($urandom));
    check_status("headless");
    check_eq("headless.ready", 64'(bus.rd_req_ready), 64'd0);

    stream_all(1'b0);
    random_reads(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
